// File: rtl/cpu32_mc.sv
// cpu32_mc: multi-cycle 32-bit CPU with a 16x32 register file and one memory
// handshake per phase (instruction fetch, data access).
//
// Parameters:
//   RESET_VECTOR  pc loaded on reset
//   TRAP_VECTOR   pc loaded on an undefined opcode (only with CPU32_TRAP_EN)
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   i_addr, i_req, i_data, i_ready  instruction fetch handshake
//   d_addr, d_data_w, d_data_r,
//   d_req, d_we, d_ready            data load/store handshake
//   retire                          one-cycle pulse per completed instruction
// Build option:
//   CPU32_TRAP_EN  defined: opcodes 5..15 trap (R15 = pc+4, pc = TRAP_VECTOR)
//                  undefined: opcodes 5..15 execute as NOP
// ALU func codes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra,
//                 8 slt, 9 sltu, others pass the second operand.
module cpu32_mc #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] i_addr,
    output logic        i_req,
    input  logic [31:0] i_data,
    input  logic        i_ready,
    output logic [31:0] d_addr,
    output logic [31:0] d_data_w,
    input  logic [31:0] d_data_r,
    output logic        d_req,
    output logic        d_we,
    input  logic        d_ready,
    output logic        retire
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StMem} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;

    logic [31:0] rf_q [16];
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [3:0]  opcode, func, fa, fb, fd;
    logic [15:0] imm16;
    logic [31:0] ra, rb, imm_z, pc_plus4, br_off;
    logic        br_take;

    assign opcode   = ir_q[31:28];
    assign func     = ir_q[27:24];
    assign fa       = ir_q[23:20];
    assign fb       = ir_q[19:16];
    assign fd       = ir_q[15:12];
    assign imm16    = ir_q[15:0];
    assign ra       = rf_q[fa];
    assign rb       = rf_q[fb];
    assign imm_z    = {16'h0000, imm16};
    assign pc_plus4 = pc_q + 32'd4;
    assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};
    assign br_take  = (func[0] && (ra == 32'd0)) || (func[1] && (ra != 32'd0));

`ifndef CPU32_TRAP_EN
    logic unused_trap_vec;
    assign unused_trap_vec = ^TRAP_VECTOR;
`endif

    function automatic logic [31:0] alu(input logic [3:0] f, input logic [31:0] x,
                                        input logic [31:0] y);
        logic [31:0] r;
        case (f)
            4'd0:    r = x + y;
            4'd1:    r = x - y;
            4'd2:    r = x & y;
            4'd3:    r = x | y;
            4'd4:    r = x ^ y;
            4'd5:    r = x << y[4:0];
            4'd6:    r = x >> y[4:0];
            4'd7:    r = $signed(x) >>> y[4:0];
            4'd8:    r = {31'd0, $signed(x) < $signed(y)};
            4'd9:    r = {31'd0, x < y};
            default: r = y;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rf_we    = 1'b0;
        rf_waddr = fb;
        rf_wdata = 32'd0;
        retire   = 1'b0;
        i_req    = 1'b0;
        d_req    = 1'b0;
        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                i_req = 1'b1;
                if (i_ready) begin
                    ir_d    = i_data;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                pc_d    = pc_plus4;
                retire  = 1'b1;
                case (opcode)
                    4'd0: begin
                        rf_we    = 1'b1;
                        rf_waddr = fd;
                        rf_wdata = alu(func, ra, rb);
                    end
                    4'd1: begin
                        rf_we    = 1'b1;
                        rf_wdata = alu(func, ra, imm_z);
                    end
                    4'd2, 4'd3: begin
                        // Address and store data are frozen here so MEM holds them stable.
                        state_d = StMem;
                        pc_d    = pc_q;
                        retire  = 1'b0;
                        addr_d  = ra + imm_z;
                        wdata_d = rb;
                        we_d    = (opcode == 4'd3);
                    end
                    4'd4: begin
                        if (br_take) begin
                            pc_d = pc_q + br_off;
                            if (func[3]) begin
                                rf_we    = 1'b1;
                                rf_wdata = pc_plus4;
                            end
                        end
                    end
                    default: begin
`ifdef CPU32_TRAP_EN
                        rf_we    = 1'b1;
                        rf_waddr = 4'd15;
                        rf_wdata = pc_plus4;
                        pc_d     = TRAP_VECTOR;
`endif
                    end
                endcase
            end
            StMem: begin
                d_req = 1'b1;
                if (d_ready) begin
                    retire  = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = StFetch;
                    if (!we_q) begin
                        rf_we    = 1'b1;
                        rf_wdata = d_data_r;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Reset abandons whatever is in flight: no write-back, no retire, no requests.
        if (reset) begin
            rf_we  = 1'b0;
            retire = 1'b0;
            i_req  = 1'b0;
            d_req  = 1'b0;
        end
    end

    assign i_addr   = pc_q;
    assign d_addr   = addr_q;
    assign d_data_w = wdata_q;
    assign d_we     = d_req & we_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_VECTOR;
            ir_q    <= 32'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    // Register file is deliberately not reset.
    always_ff @(posedge clk) begin
        if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end

endmodule

// File: tb/tb_cpu32_mc.sv
module tb_cpu32_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_addr, i_data, d_addr, d_data_w, d_data_r;
    logic        i_req, i_ready, d_req, d_we, d_ready, retire;

    int n_chk = 0;
    int n_fail = 0;
    int retire_cnt = 0;

    always #5 clk = ~clk;

    cpu32_mc dut (
        .clk      (clk),
        .reset    (reset),
        .i_addr   (i_addr),
        .i_req    (i_req),
        .i_data   (i_data),
        .i_ready  (i_ready),
        .d_addr   (d_addr),
        .d_data_w (d_data_w),
        .d_data_r (d_data_r),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_ready  (d_ready),
        .retire   (retire)
    );

    always @(posedge clk) if (retire === 1'b1) retire_cnt <= retire_cnt + 1;

    typedef struct {
        logic [31:0] instr;
        int          iwait;
        int          dwait;
        logic [31:0] rdata;
        logic [31:0] exp_fetch;
        logic        exp_mem;
        logic [31:0] exp_daddr;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and check the request-exclusivity rules.
    task automatic tick();
        @(negedge clk);
        chk("req_excl", {30'd0, i_req & d_req, d_we & ~d_req}, 32'd0);
    endtask

    task automatic run_instr(input logic [31:0] instr, input int iwait, input int dwait,
                             input logic [31:0] rdata, output logic [31:0] f_addr,
                             output int cyc, output logic is_mem, output logic [31:0] m_addr,
                             output logic [31:0] m_wdata, output logic m_we,
                             output logic m_stable);
        int n;
        n = 0;
        is_mem = 1'b0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_stable = 1'b1;
        while (i_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("fetch_seen", {31'd0, i_req}, 32'd1);
        f_addr = i_addr;
        cyc = 1;
        for (int k = 0; k < iwait; k++) begin
            i_ready = 1'b0;
            tick();
            cyc++;
        end
        i_ready = 1'b1;
        i_data  = instr;
        tick();
        cyc++;
        i_ready = 1'b0;
        i_data  = '1;
        if (retire === 1'b1) begin
            tick();
        end else begin
            tick();
            cyc++;
            is_mem  = 1'b1;
            m_addr  = d_addr;
            m_wdata = d_data_w;
            m_we    = d_we;
            for (int k = 0; k < dwait; k++) begin
                i_ready = 1'b1;  // must be ignored outside FETCH
                d_ready = 1'b0;
                m_stable &= d_req && d_addr == m_addr && d_we == m_we &&
                            d_data_w == m_wdata && !retire;
                tick();
                cyc++;
            end
            m_stable &= d_req && d_addr == m_addr && d_we == m_we && d_data_w == m_wdata;
            i_ready  = 1'b0;
            d_ready  = 1'b1;
            d_data_r = rdata;
            tick();
            d_ready  = 1'b0;
            d_data_r = '1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] f_addr, m_addr, m_wdata;
        logic        is_mem, m_we, m_stable;
        int          cyc, rc0;
        vec_t        v;

        //                instr        iw dw rdata          fetch    mem  daddr    we   wdata
        tbl.push_back('{32'h12020000, 0, 0, 32'h0,        32'h00, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h13220007, 1, 0, 32'h0,        32'h04, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h10230005, 0, 0, 32'h0,        32'h08, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h30230000, 0, 0, 32'h0,        32'h0C, 1'b1, 32'h7,   1'b1, 32'hC});
        tbl.push_back('{32'h12010000, 0, 0, 32'h0,        32'h10, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h13110100, 0, 0, 32'h0,        32'h14, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h22100008, 2, 3, 32'hDEADBEEF, 32'h18, 1'b1, 32'h108, 1'b0, 32'h0});
        tbl.push_back('{32'h30200000, 0, 0, 32'h0,        32'h1C, 1'b1, 32'h7,   1'b1, 32'hDEADBEEF});
        tbl.push_back('{32'h12040000, 0, 0, 32'h0,        32'h20, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h11410002, 0, 0, 32'h0,        32'h24, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h32100004, 0, 1, 32'h0,        32'h28, 1'b1, 32'h2,   1'b1, 32'hDEADBEEF});
        tbl.push_back('{32'h12000000, 0, 0, 32'h0,        32'h2C, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h12050000, 0, 0, 32'h0,        32'h30, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h13550003, 0, 0, 32'h0,        32'h34, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h00356000, 0, 0, 32'h0,        32'h38, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h05557000, 0, 0, 32'h0,        32'h3C, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h4B00FFFF, 0, 0, 32'h0,        32'h40, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h30200000, 0, 0, 32'h0,        32'h3C, 1'b1, 32'h7,   1'b1, 32'h44});
        tbl.push_back('{32'h12000000, 0, 0, 32'h0,        32'h40, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h4200FFFF, 0, 0, 32'h0,        32'h44, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h41020004, 0, 0, 32'h0,        32'h48, 1'b0, 32'h0,   1'b0, 32'h0});
        tbl.push_back('{32'h30020000, 0, 0, 32'h0,        32'h58, 1'b1, 32'h0,   1'b1, 32'h7});
        tbl.push_back('{32'h30060000, 0, 0, 32'h0,        32'h5C, 1'b1, 32'h0,   1'b1, 32'hF});
        tbl.push_back('{32'h30070000, 0, 0, 32'h0,        32'h60, 1'b1, 32'h0,   1'b1, 32'h18});
        tbl.push_back('{32'h50000000, 0, 0, 32'h0,        32'h64, 1'b0, 32'h0,   1'b0, 32'h0});
`ifdef CPU32_TRAP_EN
        tbl.push_back('{32'h30020000, 0, 0, 32'h0,        32'h10, 1'b1, 32'h0,   1'b1, 32'h7});
        tbl.push_back('{32'h300F0000, 0, 0, 32'h0,        32'h14, 1'b1, 32'h0,   1'b1, 32'h68});
`else
        tbl.push_back('{32'h30020000, 0, 0, 32'h0,        32'h68, 1'b1, 32'h0,   1'b1, 32'h7});
`endif

        reset = 1'b1; i_ready = 1'b0; i_data = '0; d_ready = 1'b0; d_data_r = '0;
        tick();
        tick();
        chk("in_reset_outs", {28'd0, i_req, d_req, d_we, retire}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_outs", {28'd0, i_req, d_req, d_we, retire}, 32'd0);
        d_ready = 1'b1;  // ignored outside MEM
        tick();
        d_ready = 1'b0;
        chk("first_fetch_req", {31'd0, i_req}, 32'd1);
        chk("first_fetch_addr", i_addr, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            rc0 = retire_cnt;
            run_instr(v.instr, v.iwait, v.dwait, v.rdata, f_addr, cyc, is_mem, m_addr, m_wdata,
                      m_we, m_stable);
            chk($sformatf("v%0d_fetch_addr", i), f_addr, v.exp_fetch);
            chk($sformatf("v%0d_cycles", i), 32'(cyc),
                32'(v.exp_mem ? 3 + v.iwait + v.dwait : 2 + v.iwait));
            chk($sformatf("v%0d_retires", i), 32'(retire_cnt - rc0), 32'd1);
            chk($sformatf("v%0d_is_mem", i), {31'd0, is_mem}, {31'd0, v.exp_mem});
            if (v.exp_mem) begin
                chk($sformatf("v%0d_d_addr", i), m_addr, v.exp_daddr);
                chk($sformatf("v%0d_d_we", i), {31'd0, m_we}, {31'd0, v.exp_we});
                chk($sformatf("v%0d_stable", i), {31'd0, m_stable}, 32'd1);
                if (v.exp_we) chk($sformatf("v%0d_d_data_w", i), m_wdata, v.exp_wdata);
            end
        end

        // Reset while a load to R2 is waiting in MEM.
        rc0 = 0;
        while (i_req !== 1'b1 && rc0 < 10) begin
            tick();
            rc0++;
        end
        rc0 = retire_cnt;
        i_ready = 1'b1;
        i_data  = 32'h20020000;
        tick();
        i_ready = 1'b0;
        tick();
        chk("mem_rst_in_mem", {31'd0, d_req}, 32'd1);
        tick();
        reset    = 1'b1;
        d_data_r = 32'hBAD0BAD0;
        #1;
        chk("mem_rst_during", {30'd0, d_req, retire}, 32'd0);
        tick();
        reset   = 1'b0;
        d_ready = 1'b1;  // arrives late, must be ignored in IDLE
        #1;
        chk("mem_rst_after", {29'd0, i_req, d_req, retire}, 32'd0);
        tick();
        d_ready = 1'b0;
        chk("mem_rst_refetch_req", {31'd0, i_req}, 32'd1);
        chk("mem_rst_refetch_addr", i_addr, 32'h0);
        chk("mem_rst_no_retire", 32'(retire_cnt - rc0), 32'd0);
        run_instr(32'h30020000, 0, 0, 32'h0, f_addr, cyc, is_mem, m_addr, m_wdata, m_we,
                  m_stable);
        chk("mem_rst_r2_kept", m_wdata, 32'h7);
        chk("mem_rst_store_addr", m_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
